// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - ALU op codes, multi-cycle state encodings and op-class helpers
package alu_mc_pkg;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADDU  = 5'd1;
    localparam logic [4:0] ALU_ADD   = 5'd2;
    localparam logic [4:0] ALU_SUBU  = 5'd3;
    localparam logic [4:0] ALU_SUB   = 5'd4;
    localparam logic [4:0] ALU_AND   = 5'd5;
    localparam logic [4:0] ALU_OR    = 5'd6;
    localparam logic [4:0] ALU_NOR   = 5'd7;
    localparam logic [4:0] ALU_XOR   = 5'd8;
    localparam logic [4:0] ALU_SLT   = 5'd9;
    localparam logic [4:0] ALU_SLTU  = 5'd10;
    localparam logic [4:0] ALU_EQL   = 5'd11;
    localparam logic [4:0] ALU_BNE   = 5'd12;
    localparam logic [4:0] ALU_SLL   = 5'd13;
    localparam logic [4:0] ALU_SRL   = 5'd14;
    localparam logic [4:0] ALU_SRA   = 5'd15;
    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;

    typedef enum logic [1:0] {
        ALUMC_IDLE  = 2'd0,
        ALUMC_SHIFT = 2'd1,
        ALUMC_MUL   = 2'd2,
        ALUMC_DIV   = 2'd3
    } alumc_state_e;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - iterative shift-add multiplier and restoring divider with sign fix-up
module alu_mdu_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic             div_mode;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes for the signed variants; unsigned ops pass straight through
    always_comb begin
        sign_a = is_signed && a[WIDTH-1];
        sign_b = is_signed && b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // One iteration: multiplier adds-then-shifts right, divider shifts-left-then-trial-subtracts
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        nxt_hi   = '0;
        nxt_lo   = '0;
        if (div_mode) begin
            if (div_diff[WIDTH]) begin
                nxt_hi = div_sh[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                nxt_hi = div_diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Final-iteration results with sign restoration and the divide-by-zero override
    always_comb begin
        prod   = {nxt_hi, nxt_lo};
        hi_res = '0;
        lo_res = '0;
        if (div_mode) begin
            if (div_zero) begin
                lo_res = '1;
                hi_res = dividend;
            end else begin
                lo_res = neg_res ? -nxt_lo : nxt_lo;
                hi_res = neg_rem ? -nxt_hi : nxt_hi;
            end
        end else begin
            if (neg_res) begin
                prod = -prod;
            end
            hi_res = prod[2*WIDTH-1:WIDTH];
            lo_res = prod[WIDTH-1:0];
        end
        done = busy && (cnt == CW'(WIDTH-1));
    end

    // Iteration state: loaded on start, stepped once per cycle, dropped on flush or completion
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            dividend <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            div_mode <= is_div;
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (b == '0);
            dividend <= a;
            acc_hi   <= '0;
            acc_lo   <= is_div ? mag_a : mag_b;
            opnd     <= is_div ? mag_b : mag_a;
        end else if (busy) begin
            if (flush || done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle EX-stage ALU with iterative shifter, MUL/DIV and HI/LO
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alumc_state_e state, state_nxt;

    logic [WIDTH-1:0] sh_val;
    logic [SHW-1:0]   sh_cnt;
    logic [4:0]       sh_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sh_step;
    logic             shift_last;

    logic             accept;
    logic             go_shift;
    logic             go_mul;
    logic             go_div;
    logic             go_single;

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] single_res;
    logic             single_ov;

    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;

    assign in_ready = (state == ALUMC_IDLE) && !rst;
    assign shamt    = src_a[SHW-1:0];

    alu_mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk      (clk),
        .rst      (rst),
        .start    (go_mul || go_div),
        .flush    (flush),
        .is_div   (go_div),
        .is_signed((op == ALU_MULT) || (op == ALU_DIV)),
        .a        (src_a),
        .b        (src_b),
        .done     (mdu_done),
        .hi_res   (mdu_hi),
        .lo_res   (mdu_lo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ALUMC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept decode and next state; a zero shift amount is treated as a single-cycle op
    always_comb begin
        accept     = in_valid && in_ready && !flush;
        go_shift   = accept && is_shift_op(op) && (shamt != '0);
        go_mul     = accept && is_mul_op(op);
        go_div     = accept && is_div_op(op);
        go_single  = accept && !go_shift && !go_mul && !go_div;
        shift_last = (sh_cnt == SHW'(1));
        state_nxt  = state;
        case (state)
            ALUMC_IDLE: begin
                if (go_shift) begin
                    state_nxt = ALUMC_SHIFT;
                end else if (go_mul) begin
                    state_nxt = ALUMC_MUL;
                end else if (go_div) begin
                    state_nxt = ALUMC_DIV;
                end
            end
            ALUMC_SHIFT: begin
                if (flush || shift_last) begin
                    state_nxt = ALUMC_IDLE;
                end
            end
            ALUMC_MUL, ALUMC_DIV: begin
                if (flush || mdu_done) begin
                    state_nxt = ALUMC_IDLE;
                end
            end
            default: state_nxt = ALUMC_IDLE;
        endcase
    end

    // Single-cycle arithmetic, logic and compare results with signed-overflow detection
    always_comb begin
        add_res    = src_a + src_b;
        sub_res    = src_a - src_b;
        single_res = '0;
        single_ov  = 1'b0;
        case (op)
            ALU_ADDU: single_res = add_res;
            ALU_ADD: begin
                single_res = add_res;
                single_ov  = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUBU: single_res = sub_res;
            ALU_SUB: begin
                single_res = sub_res;
                single_ov  = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND:  single_res = src_a & src_b;
            ALU_OR:   single_res = src_a | src_b;
            ALU_NOR:  single_res = ~(src_a | src_b);
            ALU_XOR:  single_res = src_a ^ src_b;
            ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            ALU_EQL:  single_res = {{(WIDTH-1){1'b0}}, src_a == src_b};
            ALU_BNE:  single_res = {{(WIDTH-1){1'b0}}, src_a != src_b};
            ALU_SLL, ALU_SRL, ALU_SRA: single_res = src_b;
            default:  single_res = '0;
        endcase
    end

    // One-bit shift step of the iterative shifter
    always_comb begin
        case (sh_op)
            ALU_SLL: sh_step = {sh_val[WIDTH-2:0], 1'b0};
            ALU_SRL: sh_step = {1'b0, sh_val[WIDTH-1:1]};
            default: sh_step = {sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
        endcase
    end

    // Result, overflow, HI/LO and shifter registers; out_valid pulses on each completion
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            sh_val    <= '0;
            sh_cnt    <= '0;
            sh_op     <= ALU_NOP;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ALUMC_IDLE: begin
                    if (go_single) begin
                        result    <= single_res;
                        overflow  <= single_ov;
                        out_valid <= 1'b1;
                    end
                    if (go_shift) begin
                        sh_val <= src_b;
                        sh_cnt <= shamt;
                        sh_op  <= op;
                    end
                end
                ALUMC_SHIFT: begin
                    if (flush) begin
                        sh_cnt <= '0;
                    end else begin
                        sh_val <= sh_step;
                        sh_cnt <= sh_cnt - SHW'(1);
                        if (shift_last) begin
                            result    <= sh_step;
                            overflow  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ALUMC_MUL, ALUMC_DIV: begin
                    if (!flush && mdu_done) begin
                        hi        <= mdu_hi;
                        lo        <= mdu_lo;
                        result    <= mdu_lo;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc with directed cases and a random reference model
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         overflow;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .out_valid(out_valid),
        .result   (result),
        .overflow (overflow),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cycles);
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ov, output int lat,
                         output logic wr, output logic [W-1:0] mh, output logic [W-1:0] ml);
        longint sa, sb, s;
        logic [63:0] p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a[4:0]);
        r = '0; ov = 1'b0; lat = 1; wr = 1'b0; mh = '0; ml = '0; p = '0; s = 0;
        case (o)
            ALU_ADDU: r = a + b;
            ALU_ADD: begin
                r = a + b; s = sa + sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUBU: r = a - b;
            ALU_SUB: begin
                r = a - b; s = sa - sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_NOR:  r = ~(a | b);
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_EQL:  r = (a == b) ? 32'd1 : 32'd0;
            ALU_BNE:  r = (a != b) ? 32'd1 : 32'd0;
            ALU_SLL:  begin r = b << sh; lat = (sh == 0) ? 1 : sh + 1; end
            ALU_SRL:  begin r = b >> sh; lat = (sh == 0) ? 1 : sh + 1; end
            ALU_SRA:  begin r = $signed(b) >>> sh; lat = (sh == 0) ? 1 : sh + 1; end
            ALU_MULT, ALU_MULTU: begin
                if (o == ALU_MULT) p = 64'(sa * sb);
                else p = {32'b0, a} * {32'b0, b};
                mh = p[63:32]; ml = p[31:0];
            end
            ALU_DIV: begin
                if (b == 0) begin ml = '1; mh = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin ml = a; mh = '0; end
                else begin ml = 32'(sa / sb); mh = 32'(sa % sb); end
            end
            ALU_DIVU: begin
                if (b == 0) begin ml = '1; mh = a; end
                else begin ml = a / b; mh = a % b; end
            end
            default: r = '0;
        endcase
        if (o == ALU_MULT || o == ALU_MULTU || o == ALU_DIV || o == ALU_DIVU) begin
            wr = 1'b1; lat = W + 1; r = ml;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = ALU_NOP; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (result !== '0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        n_checks++; if ({hi, lo} !== '0) $display("FAIL reset_hilo: got %h_%h expected 0", hi, lo); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_add_overflow();
        int lat, busy;
        run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, lat, busy);
        n_checks++; if (result !== 32'h8000_0000) $display("FAIL add_result: got %h expected 80000000", result); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL add_overflow: got %b expected 1", overflow); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL add_latency: got %0d expected 1", lat); else n_pass++;
        run_op(ALU_ADDU, 32'h7FFF_FFFF, 32'h1, lat, busy);
        n_checks++; if (overflow !== 1'b0) $display("FAIL addu_overflow: got %b expected 0", overflow); else n_pass++;
        n_checks++; if (result !== 32'h8000_0000) $display("FAIL addu_result: got %h expected 80000000", result); else n_pass++;
        run_op(ALU_SUB, 32'h8000_0000, 32'h1, lat, busy);
        n_checks++; if (overflow !== 1'b1) $display("FAIL sub_overflow: got %b expected 1", overflow); else n_pass++;
        n_checks++; if (result !== 32'h7FFF_FFFF) $display("FAIL sub_result: got %h expected 7fffffff", result); else n_pass++;
    endtask

    task automatic test_shift();
        int lat, busy;
        run_op(ALU_SRA, 32'h24, 32'hF000_0000, lat, busy);
        n_checks++; if (result !== 32'hFF00_0000) $display("FAIL sra_result: got %h expected ff000000", result); else n_pass++;
        n_checks++; if (lat !== 5) $display("FAIL sra_latency: got %0d expected 5", lat); else n_pass++;
        n_checks++; if (busy !== 4) $display("FAIL sra_busy_cycles: got %0d expected 4", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL sra_ready_at_done: got %b expected 1", in_ready); else n_pass++;
        run_op(ALU_SLL, 32'h20, 32'h1234_5678, lat, busy);
        n_checks++; if (result !== 32'h1234_5678) $display("FAIL sll0_result: got %h expected 12345678", result); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL sll0_latency: got %0d expected 1", lat); else n_pass++;
        run_op(ALU_SRL, 32'h1F, 32'h8000_0000, lat, busy);
        n_checks++; if (result !== 32'h1) $display("FAIL srl31_result: got %h expected 1", result); else n_pass++;
        n_checks++; if (lat !== 32) $display("FAIL srl31_latency: got %0d expected 32", lat); else n_pass++;
    endtask

    task automatic test_mul();
        int lat, busy;
        run_op(ALU_MULT, 32'hFFFF_FFFD, 32'd5, lat, busy);
        n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi); else n_pass++;
        n_checks++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo: got %h expected fffffff1", lo); else n_pass++;
        n_checks++; if (result !== 32'hFFFF_FFF1) $display("FAIL mult_result: got %h expected fffffff1", result); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL mult_latency: got %0d expected 33", lat); else n_pass++;
        run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, lat, busy);
        n_checks++; if (hi !== 32'h1) $display("FAIL multu_hi: got %h expected 1", hi); else n_pass++;
        n_checks++; if (lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h expected fffffffe", lo); else n_pass++;
    endtask

    task automatic test_div();
        int lat, busy;
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat, busy);
        n_checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", lo); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", hi); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL div_latency: got %0d expected 33", lat); else n_pass++;
        run_op(ALU_DIVU, 32'd7, 32'd0, lat, busy);
        n_checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo: got %h expected ffffffff", lo); else n_pass++;
        n_checks++; if (hi !== 32'd7) $display("FAIL divu0_hi: got %h expected 7", hi); else n_pass++;
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy);
        n_checks++; if (lo !== 32'h8000_0000) $display("FAIL divmin_lo: got %h expected 80000000", lo); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL divmin_hi: got %h expected 0", hi); else n_pass++;
    endtask

    task automatic test_flush();
        int lat, busy;
        logic seen;
        run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, lat, busy);
        @(posedge clk); #1;
        in_valid = 1'b1; op = ALU_DIV; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", in_ready); else n_pass++;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", seen); else n_pass++;
        n_checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) $display("FAIL flush_hilo: got %h_%h expected 00000001_fffffffe", hi, lo); else n_pass++;
        in_valid = 1'b1; flush = 1'b1; op = ALU_ADDU; src_a = 32'd1; src_b = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_idle_accept: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_rst_abort();
        logic seen;
        @(posedge clk); #1;
        in_valid = 1'b1; op = ALU_DIV; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", seen); else n_pass++;
        n_checks++; if (hi !== '0 || lo !== '0) $display("FAIL rst_hilo: got %h_%h expected 0_0", hi, lo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic extra;
        @(posedge clk); #1;
        in_valid = 1'b1; op = ALU_SLT; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd1) $display("FAIL b2b_slt: got v=%b r=%h expected v=1 r=1", out_valid, result); else n_pass++;
        op = ALU_SLTU;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd0) $display("FAIL b2b_sltu: got v=%b r=%h expected v=1 r=0", out_valid, result); else n_pass++;
        op = ALU_XOR; src_a = 32'hFF00_FF00; src_b = 32'h0FF0_0FF0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || result !== 32'hF0F0_F0F0) $display("FAIL b2b_xor: got v=%b r=%h expected v=1 r=f0f0f0f0", out_valid, result); else n_pass++;
        // Busy drop: an op offered while MULT is in flight must vanish
        @(posedge clk); #1;
        in_valid = 1'b1; op = ALU_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b1; op = ALU_XOR; src_a = 32'd1; src_b = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (result !== 32'hFFFF_FFF1) $display("FAIL busy_drop_result: got %h expected fffffff1", result); else n_pass++;
        extra = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (out_valid) extra = 1'b1; end
        n_checks++; if (extra !== 1'b0) $display("FAIL busy_drop_extra: got %b expected 0", extra); else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0]   ops [22];
        logic [4:0]   o;
        logic [W-1:0] a, b, er, m_hi, m_lo, mh, ml;
        logic         eov, wr;
        int           elat, lat, busy;
        ops = '{ALU_NOP, ALU_ADDU, ALU_ADD, ALU_SUBU, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
                ALU_XOR, ALU_SLT, ALU_SLTU, ALU_EQL, ALU_BNE, ALU_SLL, ALU_SRL, ALU_SRA,
                ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, 5'd20, 5'd31};
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 21)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: a = b;
                default: ;
            endcase
            model(o, a, b, er, eov, elat, wr, mh, ml);
            if (wr) begin m_hi = mh; m_lo = ml; end
            run_op(o, a, b, lat, busy);
            n_checks++; if (result !== er) $display("FAIL rand_result op=%0d a=%h b=%h: got %h expected %h", o, a, b, result, er); else n_pass++;
            n_checks++; if (overflow !== eov) $display("FAIL rand_overflow op=%0d a=%h b=%h: got %b expected %b", o, a, b, overflow, eov); else n_pass++;
            n_checks++; if (lat !== elat) $display("FAIL rand_latency op=%0d a=%h: got %0d expected %0d", o, a, lat, elat); else n_pass++;
            n_checks++; if (hi !== m_hi) $display("FAIL rand_hi op=%0d a=%h b=%h: got %h expected %h", o, a, b, hi, m_hi); else n_pass++;
            n_checks++; if (lo !== m_lo) $display("FAIL rand_lo op=%0d a=%h b=%h: got %h expected %h", o, a, b, lo, m_lo); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_shift();
        test_mul();
        test_div();
        test_flush();
        test_rst_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
